pc_fetch: RTL and testbench

//   Program counter and next-PC stage of the single-cycle MIPS datapath; drives the

---
 rtl/pc_fetch.sv | 129 ++++++++++++
 tb/tb_pc_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Program counter and next-PC select for a single-cycle MIPS datapath.
// A RUN/HALT/FAULT state machine freezes fetch on a halt word or an illegal target.
module pc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] instr,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        zero,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] rs_value,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] instr_count
);

    localparam logic [31:0] PC_LIMIT  = 32'(MEM_WORDS * 32'd4);
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] fault_addr_r;
    logic [31:0] fault_addr_next_s;
    logic [31:0] instr_count_r;
    logic [31:0] count_next_s;
    logic        halted_r;
    logic        fault_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] branch_off_s;
    logic [31:0] target_s;
    logic        taken_s;
    logic        illegal_s;

    // A target is unusable when it is not word aligned or lies beyond the ROM.
    function automatic logic target_illegal(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= PC_LIMIT);
    endfunction

    assign pc_plus4_s   = pc_r + 32'd4;
    assign branch_off_s = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign taken_s      = (branch_eq & zero) | (branch_ne & ~zero);

    // Prioritised next-target select: jr, then j/jal, then taken branch, then sequential.
    always_comb begin
        target_s = pc_plus4_s;
        if (jump_reg) begin
            target_s = rs_value;
        end else if (jump) begin
            target_s = {pc_plus4_s[31:28], instr[25:0], 2'b00};
        end else if (taken_s) begin
            target_s = pc_plus4_s + branch_off_s;
        end else begin
            target_s = pc_plus4_s;
        end
        illegal_s = target_illegal(target_s);
    end

    // Next-state and next-register values; everything holds unless RUN advances.
    always_comb begin
        state_next_s      = state_r;
        pc_next_s         = pc_r;
        fault_addr_next_s = fault_addr_r;
        count_next_s      = instr_count_r;
        case (state_r)
            ST_RUN: begin
                if (!enable) begin
                    state_next_s = ST_RUN;
                end else if (instr == HALT_WORD) begin
                    state_next_s = ST_HALT;
                end else if (illegal_s) begin
                    state_next_s      = ST_FAULT;
                    fault_addr_next_s = target_s;
                end else begin
                    pc_next_s    = target_s;
                    count_next_s = (instr_count_r == COUNT_MAX) ? COUNT_MAX
                                                                : instr_count_r + 32'd1;
                end
            end
            ST_HALT:  state_next_s = ST_HALT;
            ST_FAULT: state_next_s = ST_FAULT;
            // An unencoded state is treated as a fault so fetch stays frozen.
            default:  state_next_s = ST_FAULT;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            fault_addr_r  <= 32'h0000_0000;
            instr_count_r <= 32'h0000_0000;
            halted_r      <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            fault_addr_r  <= fault_addr_next_s;
            instr_count_r <= count_next_s;
            halted_r      <= (state_next_s == ST_HALT);
            fault_r       <= (state_next_s == ST_FAULT);
        end
    end

    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign halted      = halted_r;
    assign fault       = fault_r;
    assign fault_addr  = fault_addr_r;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a behavioural next-PC model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_pc_fetch;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] HALT_W = 32'h0000_000C;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [31:0] instr;
    logic        branch_eq;
    logic        branch_ne;
    logic        zero;
    logic        jump;
    logic        jump_reg;
    logic [31:0] rs_value;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] instr_count;

    int total = 0;
    int bad   = 0;
    logic chk_en   = 1'b0;
    logic sat_load = 1'b0;

    pc_fetch #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(64),
        .HALT_WORD(HALT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .instr      (instr),
        .branch_eq  (branch_eq),
        .branch_ne  (branch_ne),
        .zero       (zero),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .rs_value   (rs_value),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .halted     (halted),
        .fault      (fault),
        .fault_addr (fault_addr),
        .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: plain arithmetic on the architectural rules.
    logic [31:0] m_pc, m_faddr, m_count;
    logic        m_halted, m_faulted;
    logic [31:0] m_target;

    function automatic logic [31:0] model_target(input logic [31:0] cur_pc, input logic [31:0] ins,
                                                 input logic beq, input logic bne, input logic z,
                                                 input logic j, input logic jr, input logic [31:0] rs);
        logic [31:0]        p4;
        logic signed [15:0] imm;
        int                 off;
        p4  = cur_pc + 32'd4;
        imm = ins[15:0];
        off = int'(imm) * 4;
        if (jr) return rs;
        if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if ((beq && z) || (bne && !z)) return p4 + 32'(off);
        return p4;
    endfunction

    assign m_target = model_target(m_pc, instr, branch_eq, branch_ne, zero, jump, jump_reg, rs_value);

    always @(posedge clock) begin
        if (reset) begin
            m_pc      <= 32'h0000_0000;
            m_halted  <= 1'b0;
            m_faulted <= 1'b0;
            m_faddr   <= 32'h0000_0000;
            m_count   <= 32'h0000_0000;
        end else if (sat_load) begin
            m_count <= 32'hFFFF_FFFE;
        end else if (!m_halted && !m_faulted && enable) begin
            if (instr == HALT_W) begin
                m_halted <= 1'b1;
            end else if ((m_target % 32'd4) != 32'd0 || m_target >= 32'd256) begin
                m_faulted <= 1'b1;
                m_faddr   <= m_target;
            end else begin
                m_pc <= m_target;
                if (m_count != 32'hFFFF_FFFF) m_count <= m_count + 32'd1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_pc",       pc,          m_pc);
            chk("m_pc_plus4", pc_plus4,    m_pc + 32'd4);
            chk("m_halted",   {31'b0, halted}, {31'b0, m_halted});
            chk("m_fault",    {31'b0, fault},  {31'b0, m_faulted});
            chk("m_faddr",    fault_addr,  m_faddr);
            chk("m_count",    instr_count, m_count);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_in();
        enable    = 1'b1;
        instr     = NOP;
        branch_eq = 1'b0;
        branch_ne = 1'b0;
        zero      = 1'b0;
        jump      = 1'b0;
        jump_reg  = 1'b0;
        rs_value  = 32'h0000_0000;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        step();
        chk_en = 1'b1;
        chk("rst_pc",    pc, 32'h0);
        chk("rst_count", instr_count, 32'h0);
        chk("rst_halt",  {31'b0, halted}, 32'h0);
        reset = 1'b0;

        // sequential fetch
        repeat (3) step();
        chk("seq_pc",    pc, 32'd12);
        chk("seq_count", instr_count, 32'd3);

        // stall holds everything
        enable = 1'b0;
        repeat (4) step();
        chk("stall_pc",    pc, 32'd12);
        chk("stall_count", instr_count, 32'd3);
        enable = 1'b1;
        step();
        chk("resume_pc",    pc, 32'd16);
        chk("resume_count", instr_count, 32'd4);

        // beq / bne with negative and positive offsets
        do_reset();
        repeat (2) step();
        chk("pre_br_pc", pc, 32'd8);
        instr = 32'h1000_FFFE; branch_eq = 1'b1; zero = 1'b0;
        step();
        chk("beq_nt_pc", pc, 32'd12);
        zero = 1'b1;
        step();
        chk("beq_t_pc", pc, 32'd8);
        step();
        chk("beq_t2_pc", pc, 32'd4);
        branch_eq = 1'b0; branch_ne = 1'b1; zero = 1'b0; instr = 32'h1400_0003;
        step();
        chk("bne_t_pc", pc, 32'h14);
        zero = 1'b1;
        step();
        chk("bne_nt_pc", pc, 32'h18);

        // jr beats j; misaligned jr faults
        do_reset();
        step();
        instr = 32'h0800_0010; jump = 1'b1; jump_reg = 1'b1; rs_value = 32'h20;
        step();
        chk("jr_pc", pc, 32'h20);
        rs_value = 32'h22;
        step();
        chk("mis_fault", {31'b0, fault}, 32'd1);
        chk("mis_faddr", fault_addr, 32'h22);
        chk("mis_pc",    pc, 32'h20);
        chk("mis_count", instr_count, 32'd2);
        jump_reg = 1'b0;
        repeat (3) step();
        chk("fault_frozen_pc", pc, 32'h20);

        // reset clears a fault; halt then freezes fetch
        do_reset();
        chk("clr_fault", {31'b0, fault}, 32'd0);
        chk("clr_pc",    pc, 32'd0);
        repeat (4) step();
        instr = HALT_W;
        step();
        chk("halt_flag",  {31'b0, halted}, 32'd1);
        chk("halt_pc",    pc, 32'd16);
        chk("halt_count", instr_count, 32'd4);
        instr = 32'h0800_0000; jump = 1'b1;
        repeat (5) step();
        chk("halt_frozen_pc", pc, 32'd16);
        do_reset();
        chk("unhalt_pc",   pc, 32'd0);
        chk("unhalt_flag", {31'b0, halted}, 32'd0);

        // j beyond the ROM
        instr = 32'h0800_0040; jump = 1'b1;
        step();
        chk("j_oob_fault", {31'b0, fault}, 32'd1);
        chk("j_oob_faddr", fault_addr, 32'h100);
        chk("j_oob_pc",    pc, 32'd0);

        // last legal word, then sequential overrun
        do_reset();
        jump_reg = 1'b1; rs_value = 32'hFC;
        step();
        chk("last_pc",    pc, 32'hFC);
        chk("last_fault", {31'b0, fault}, 32'd0);
        jump_reg = 1'b0;
        step();
        chk("over_faddr", fault_addr, 32'h100);
        chk("over_pc",    pc, 32'hFC);

        // counter saturation
        do_reset();
        enable   = 1'b0;
        sat_load = 1'b1;
        @(posedge clock);
        #1 force dut.instr_count_r = 32'hFFFF_FFFE;
        #1 release dut.instr_count_r;
        sat_load = 1'b0;
        chk("sat_pre", instr_count, 32'hFFFF_FFFE);
        enable = 1'b1;
        step();
        chk("sat_max", instr_count, 32'hFFFF_FFFF);
        repeat (2) step();
        chk("sat_hold", instr_count, 32'hFFFF_FFFF);
        chk("sat_pc",   pc, 32'd12);

        @(negedge clock);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
